// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared width codes, FSM states and request legality check
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A request is rejected before any memory traffic if its width code is
    // undefined, its address is not naturally aligned, or it is an unsigned store.
    function automatic logic request_fault(input logic is_store, input logic [2:0] f3,
                                           input logic [1:0] lo);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = lo[0];
            F3_W:        bad = (lo != 2'b00);
            default:     bad = 1'b1;
        endcase
        if (is_store && (f3 > F3_W)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - lane extraction/extension for loads and lane merge for sub-word stores
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [2:0]  funct3,
    input  logic [15:0] store_data,
    output logic [31:0] load_value,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_value;
    logic [15:0] half_value;

    always_comb begin
        byte_value  = word[{lane, 3'b000} +: 8];
        half_value  = lane[1] ? word[31:16] : word[15:0];
        load_value  = word;
        merged_word = word;
        case (funct3)
            F3_B:    load_value = {{24{byte_value[7]}}, byte_value};
            F3_BU:   load_value = {24'h0, byte_value};
            F3_H:    load_value = {{16{half_value[15]}}, half_value};
            F3_HU:   load_value = {16'h0, half_value};
            default: load_value = word;
        endcase
        // Only SB/SH reach the merge path; other codes pass the word through.
        if (funct3 == F3_B) begin
            merged_word[{lane, 3'b000} +: 8] = store_data[7:0];
        end else if (funct3 == F3_H) begin
            merged_word[{lane[1], 4'b0000} +: 16] = store_data;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store initiator turning RISC-V LB..SW requests into word accesses
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDRESSLEN = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic                  isStore,
    input  logic [2:0]            funct3,
    input  logic [ADDRESSLEN-1:0] address,
    input  logic [XLEN-1:0]       storeData,
    output logic                  ready,
    output logic                  done,
    output logic                  fault,
    output logic [XLEN-1:0]       loadData,
    output logic [ADDRESSLEN-1:0] memReadAddress,
    output logic                  memReadEnabled,
    output logic [ADDRESSLEN-1:0] memWriteAddress,
    output logic                  memWriteEnabled,
    output logic [XLEN-1:0]       memWriteData,
    input  logic [XLEN-1:0]       memOut
);

    state_t                state_q;
    state_t                state_d;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [ADDRESSLEN-1:0] addr_q;
    logic [XLEN-1:0]       word_q;
    logic                  fault_q;
    logic [XLEN-1:0]       load_data_q;

    logic                  accept_fault;
    logic [31:0]           load_value;
    logic [31:0]           merged_word;
    logic [ADDRESSLEN-1:0] word_addr;

    assign accept_fault = request_fault(isStore, funct3, address[1:0]);
    assign word_addr    = {addr_q[ADDRESSLEN-1:2], 2'b00};

    mem_lane_align u_align (
        .word        (memOut),
        .lane        (addr_q[1:0]),
        .funct3      (funct3_q),
        .store_data  (word_q[15:0]),
        .load_value  (load_value),
        .merged_word (merged_word)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (accept_fault) begin
                        state_d = DONE;
                    end else if (isStore && (funct3 == F3_W)) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ:    state_d = is_store_q ? WRITE : DONE;
            WRITE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'd0;
            addr_q      <= '0;
            word_q      <= '0;
            fault_q     <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (req) begin
                        is_store_q <= isStore;
                        funct3_q   <= funct3;
                        addr_q     <= address;
                        // Holds SW data directly; SB/SH overwrite it with the merged word.
                        word_q     <= storeData;
                        fault_q    <= accept_fault;
                    end
                end
                READ: begin
                    if (is_store_q) begin
                        word_q <= merged_word;
                    end else begin
                        load_data_q <= load_value;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory-side outputs depend on state only, so an async reset drops them at once.
    assign ready           = (state_q == IDLE);
    assign done            = (state_q == DONE);
    assign fault           = (state_q == DONE) && fault_q;
    assign loadData        = load_data_q;
    assign memReadEnabled  = (state_q == READ);
    assign memReadAddress  = (state_q == READ) ? word_addr : '0;
    assign memWriteEnabled = (state_q == WRITE);
    assign memWriteAddress = (state_q == WRITE) ? word_addr : '0;
    assign memWriteData    = (state_q == WRITE) ? word_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - directed vector bench for mem_access_unit with a small memData model
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        isStore = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] address = 32'h0;
    logic [31:0] storeData = 32'h0;
    logic        ready, done, fault;
    logic [31:0] loadData;
    logic [31:0] memReadAddress, memWriteAddress, memWriteData;
    logic        memReadEnabled, memWriteEnabled;
    logic [31:0] memOut;

    logic        init_mem = 1'b1;
    logic [31:0] mem [0:31];
    int          total = 0;
    int          bad = 0;
    int          viol = 0;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .isStore         (isStore),
        .funct3          (funct3),
        .address         (address),
        .storeData       (storeData),
        .ready           (ready),
        .done            (done),
        .fault           (fault),
        .loadData        (loadData),
        .memReadAddress  (memReadAddress),
        .memReadEnabled  (memReadEnabled),
        .memWriteAddress (memWriteAddress),
        .memWriteEnabled (memWriteEnabled),
        .memWriteData    (memWriteData),
        .memOut          (memOut)
    );

    // memData model: 32 words, write on posedge, read captured on negedge
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h0;
            mem[2] <= 32'h8899AABB;
        end else if (memWriteEnabled) begin
            mem[memWriteAddress[6:2]] <= memWriteData;
        end
    end

    always @(negedge clk) begin
        if (memReadEnabled) memOut <= mem[memReadAddress[6:2]];
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (memReadEnabled && memWriteEnabled) viol++;
            if (!memReadEnabled && memReadAddress != 32'h0) viol++;
            if (!memWriteEnabled && (memWriteAddress != 32'h0 || memWriteData != 32'h0)) viol++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd, output int lat, output int nrd,
                          output int nwr, output logic flt);
        req = 1'b1; isStore = st; funct3 = f3; address = a; storeData = sd;
        nrd = 0; nwr = 0;
        @(posedge clk); #1;
        req = 1'b0;
        lat = 1;
        while (!done && lat < 20) begin
            if (memReadEnabled) nrd++;
            if (memWriteEnabled) nwr++;
            @(posedge clk); #1;
            lat++;
        end
        flt = fault;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] sd;
        logic [31:0] exp_load;
        logic        exp_fault;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_w2;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int lat, nrd, nwr, cyc, nd, d1, d2;
        logic flt;

        vecs[0]  = '{1'b0, 3'd0, 32'hB, 32'h0,         32'hFFFFFF88, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[1]  = '{1'b0, 3'd4, 32'hB, 32'h0,         32'h00000088, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[2]  = '{1'b0, 3'd5, 32'hA, 32'h0,         32'h00008899, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[3]  = '{1'b0, 3'd1, 32'h8, 32'h0,         32'hFFFFAABB, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[4]  = '{1'b0, 3'd0, 32'h8, 32'h0,         32'hFFFFFFBB, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[5]  = '{1'b0, 3'd4, 32'h9, 32'h0,         32'h000000AA, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[6]  = '{1'b0, 3'd1, 32'hA, 32'h0,         32'hFFFF8899, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[7]  = '{1'b0, 3'd2, 32'h8, 32'h0,         32'h8899AABB, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[8]  = '{1'b0, 3'd2, 32'h6, 32'h0,         32'h8899AABB, 1'b1, 1, 0, 0, 32'h8899AABB};
        vecs[9]  = '{1'b1, 3'd1, 32'h5, 32'h11112222,  32'h8899AABB, 1'b1, 1, 0, 0, 32'h8899AABB};
        vecs[10] = '{1'b0, 3'd3, 32'h8, 32'h0,         32'h8899AABB, 1'b1, 1, 0, 0, 32'h8899AABB};
        vecs[11] = '{1'b1, 3'd4, 32'h8, 32'h000000EE,  32'h8899AABB, 1'b1, 1, 0, 0, 32'h8899AABB};
        vecs[12] = '{1'b0, 3'd7, 32'h8, 32'h0,         32'h8899AABB, 1'b1, 1, 0, 0, 32'h8899AABB};
        vecs[13] = '{1'b1, 3'd0, 32'h9, 32'h123456CC,  32'h8899AABB, 1'b0, 3, 1, 1, 32'h8899CCBB};
        vecs[14] = '{1'b1, 3'd1, 32'hA, 32'h12345678,  32'h8899AABB, 1'b0, 3, 1, 1, 32'h5678CCBB};
        vecs[15] = '{1'b0, 3'd2, 32'h8, 32'h0,         32'h5678CCBB, 1'b0, 2, 1, 0, 32'h5678CCBB};
        vecs[16] = '{1'b1, 3'd2, 32'h8, 32'hCAFEF00D,  32'h5678CCBB, 1'b0, 2, 0, 1, 32'hCAFEF00D};
        vecs[17] = '{1'b0, 3'd5, 32'hA, 32'h0,         32'h0000CAFE, 1'b0, 2, 1, 0, 32'hCAFEF00D};

        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", {31'h0, ready}, 32'h1);
        check("reset_done", {31'h0, done}, 32'h0);
        check("reset_fault", {31'h0, fault}, 32'h0);
        check("reset_loaddata", loadData, 32'h0);
        check("reset_enables", {30'h0, memReadEnabled, memWriteEnabled}, 32'h0);
        init_mem = 1'b0;
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            run_op(vecs[i].st, vecs[i].f3, vecs[i].a, vecs[i].sd, lat, nrd, nwr, flt);
            check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
            check($sformatf("v%0d_fault", i), {31'h0, flt}, {31'h0, vecs[i].exp_fault});
            check($sformatf("v%0d_loaddata", i), loadData, vecs[i].exp_load);
            check($sformatf("v%0d_reads", i), nrd, vecs[i].exp_rd);
            check($sformatf("v%0d_writes", i), nwr, vecs[i].exp_wr);
            check($sformatf("v%0d_word8", i), mem[2], vecs[i].exp_w2);
        end

        // SW then LW back-to-back with req held high through the busy cycles
        req = 1'b1; isStore = 1'b1; funct3 = 3'd2; address = 32'h10; storeData = 32'hDEADBEEF;
        @(posedge clk); #1;
        isStore = 1'b0; storeData = 32'h0;
        cyc = 1; nd = 0; d1 = 0; d2 = 0;
        while (nd < 2 && cyc < 30) begin
            if (done) begin
                nd++;
                if (nd == 1) d1 = cyc; else d2 = cyc;
            end
            if (nd < 2) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        req = 1'b0;
        check("b2b_sw_done_cycle", d1, 2);
        check("b2b_lw_done_cycle", d2, 5);
        check("b2b_word10", mem[4], 32'hDEADBEEF);
        check("b2b_loaddata", loadData, 32'hDEADBEEF);
        @(posedge clk); #1;

        // reset asserted while SH is in WRITE must suppress the write
        init_mem = 1'b1;
        @(posedge clk); #1;
        init_mem = 1'b0;
        req = 1'b1; isStore = 1'b1; funct3 = 3'd1; address = 32'h8; storeData = 32'h00001111;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        check("rst_pre_write_en", {31'h0, memWriteEnabled}, 32'h1);
        reset = 1'b1;
        #1;
        check("rst_write_en_dropped", {31'h0, memWriteEnabled}, 32'h0);
        @(posedge clk); #1;
        check("rst_word8_kept", mem[2], 32'h8899AABB);
        check("rst_ready", {31'h0, ready}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_loaddata", loadData, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        check("bus_exclusivity_violations", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
